fetch_pc_ctrl: RTL and testbench
================================

// Module: fetch_pc_ctrl
// PURPOSE
//  Fetch-stage PC control for the Y86-64 pipeline: holds the F pipeline register (predicted PC), selects the
//  fetch address, predicts the next PC and classifies fetch status.
//  Drives f_pc into instruction memory; consumes the split, align and pc_increment results; feeds D.
//  A run/drain/halt FSM freezes fetch after a halt, bad address or illegal instruction until writeback resolves it.
// PARAMETERS
//  RESET_PC  64'd0  F_predPC value on reset
//  COUNT_W   32     width of accepted-instruction counter
// PORTS
//  clk           in   1   pipeline clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  F_stall       in   1   hold F register (load/use or ret hazard)
//  f_icode       in   4   icode of byte at f_pc
//  f_ifun        in   4   ifun of byte at f_pc
//  f_valC        in   64  constant word from align
//  f_valP        in   64  incremented PC from pc_increment
//  imem_error    in   1   instruction memory address error
//  instr_valid   in   1   f_icode is legal
//  M_icode       in   4   icode in M register
//  M_Cnd         in   1   condition outcome in M
//  M_valA        in   64  recovery target carried by a jXX in M
//  W_icode       in   4   icode in W register
//  W_valM        in   64  return address read by ret in W
//  W_stat        in   3   status in W
//  f_pc          out  64  selected fetch address (combinational)
//  f_predPC      out  64  predicted next PC (combinational)
//  f_stat        out  3   fetch status: AOK=1 HLT=2 ADR=3 INS=4
//  f_bubble      out  1   D loads a nop bubble this cycle
//  halted        out  1   FSM in HALTED
//  fetch_count   out  COUNT_W  accepted AOK fetches, wraps at 2^COUNT_W
// BEHAVIOUR
//  Select: redirect_jmp = M_icode==JXX && !M_Cnd -> f_pc=M_valA; else W_icode==RET -> W_valM; else F_predPC.
//  Predict: f_icode in {JXX,CALL} -> f_valC; else f_valP.
//  f_stat priority: imem_error -> ADR; !instr_valid -> INS; f_icode==HALT -> HLT; else AOK.
//  accept = state==RUN && !F_stall; redirect = redirect_jmp || W_icode==RET.
//  F_predPC load: on accept, or on redirect in any non-HALTED state. Redirect overrides F_stall.
//   Otherwise hold. Async reset -> RESET_PC.
//  FSM, reset -> RUN:
//   RUN -> DRAIN on accept with f_stat!=AOK (the faulting instruction itself passes to D).
//   DRAIN: F_predPC frozen; f_bubble=1. DRAIN -> RUN on redirect (the fault was on the wrong path).
//    DRAIN -> HALTED when W_stat!=AOK. If both occur in one cycle, HALTED wins.
//   HALTED: sticky until rst_n; f_bubble=1; redirects ignored.
//  f_bubble=0 in RUN. fetch_count increments on accept && f_stat==AOK && !redirect.
//  Reset values: F_predPC=RESET_PC, state=RUN, fetch_count=0, halted=0.
//  Reset mid-operation (any state) returns to these values immediately. Latency: f_pc to F_predPC is one cycle.
// CONFIGURATION
//  BTFNT_PRED_EN defined: backward-taken/forward-not-taken prediction.
//   jXX with ifun==0, or f_valC<=f_pc -> predict f_valC; otherwise predict f_valP.
//   Adds out f_pred_taken[1] and in M_pred_taken[1].
//   redirect_jmp = M_icode==JXX && M_Cnd!=M_pred_taken, with M_valA holding the non-predicted address.
//  Undefined: always-taken prediction, as in Select/Predict above; those two ports are absent.
// STRUCTURE
//  y86_pkg: icode constants (HALT..POPQ = 0..B), STAT_AOK/HLT/ADR/INS, FSM state encoding.
//  Sub-module pc_select: combinational select and predict logic.
//  FSM, F register and counter stay in the top module.
// TESTING
//  Reset with RESET_PC=0x40 -> f_pc=0x40, f_stat=AOK, fetch_count=0, halted=0.
//  nop stream, f_valP=pc+1, F_stall=0 for 3 cycles -> f_pc 0x40,0x41,0x42; fetch_count=3.
//  jXX valC=0x100 at 0x40, later M_icode=JXX, M_Cnd=0, M_valA=0x49 -> f_pc=0x49 that cycle, then 0x49's f_predPC.
//  halt fetched -> f_stat=HLT, state DRAIN, f_bubble=1.
//   W_stat=HLT 3 cycles later -> halted=1; stays 1 despite W_icode=RET.
//  imem_error in RUN, then mispredict redirect before W sees ADR -> back to RUN; no halt.
//  F_stall=1 with W_icode=RET, W_valM=0x80 -> F_predPC loads next PC from 0x80.
//   Assert rst_n=0 mid-DRAIN -> RUN, F_predPC=RESET_PC.

Source files
------------

// File: rtl/fetch_pc_ctrl_pkg.sv
// Y86-64 fetch-stage shared definitions: icodes, status codes, fetch FSM states.
// Used by fetch_pc_ctrl, pc_select and fetch_pc_ctrl_if.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // Address errors dominate illegal encodings, which dominate a legal halt.
  function automatic logic [2:0] fetch_status(input logic       imem_error,
                                              input logic       instr_valid,
                                              input logic [3:0] icode);
    if (imem_error)          return STAT_ADR;
    else if (!instr_valid)   return STAT_INS;
    else if (icode == I_HALT) return STAT_HLT;
    else                     return STAT_AOK;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Signal bundle between the fetch PC controller and the rest of the pipeline.
// BTFNT_PRED_EN adds the prediction-direction signals f_pred_taken / M_pred_taken.
interface fetch_pc_ctrl_if #(parameter int COUNT_W = 32);

  logic               F_stall;
  logic [3:0]         f_icode;
  logic [3:0]         f_ifun;
  logic [63:0]        f_valC;
  logic [63:0]        f_valP;
  logic               imem_error;
  logic               instr_valid;
  logic [3:0]         M_icode;
  logic               M_Cnd;
  logic [63:0]        M_valA;
  logic [3:0]         W_icode;
  logic [63:0]        W_valM;
  logic [2:0]         W_stat;
  logic [63:0]        f_pc;
  logic [63:0]        f_predPC;
  logic [2:0]         f_stat;
  logic               f_bubble;
  logic               halted;
  logic [COUNT_W-1:0] fetch_count;
`ifdef BTFNT_PRED_EN
  logic               f_pred_taken;
  logic               M_pred_taken;
`endif

  modport master (
    output F_stall, f_icode, f_ifun, f_valC, f_valP, imem_error, instr_valid,
           M_icode, M_Cnd, M_valA, W_icode, W_valM, W_stat,
`ifdef BTFNT_PRED_EN
    output M_pred_taken,
    input  f_pred_taken,
`endif
    input  f_pc, f_predPC, f_stat, f_bubble, halted, fetch_count
  );

  modport slave (
    input  F_stall, f_icode, f_ifun, f_valC, f_valP, imem_error, instr_valid,
           M_icode, M_Cnd, M_valA, W_icode, W_valM, W_stat,
`ifdef BTFNT_PRED_EN
    input  M_pred_taken,
    output f_pred_taken,
`endif
    output f_pc, f_predPC, f_stat, f_bubble, halted, fetch_count
  );

endinterface

// File: rtl/fetch_pc_ctrl_pc_select.sv
// Combinational fetch-address select and next-PC prediction.
// BTFNT_PRED_EN switches from always-taken to backward-taken/forward-not-taken.
module pc_select
  import y86_pkg::*;
(
  input  logic [63:0] predPc_i,
  input  logic [3:0]  f_icode_i,
`ifdef BTFNT_PRED_EN
  input  logic [3:0]  f_ifun_i,
  input  logic        M_pred_taken_i,
  output logic        f_pred_taken_o,
`endif
  input  logic [63:0] f_valC_i,
  input  logic [63:0] f_valP_i,
  input  logic [3:0]  M_icode_i,
  input  logic        M_Cnd_i,
  input  logic [63:0] M_valA_i,
  input  logic [3:0]  W_icode_i,
  input  logic [63:0] W_valM_i,
  output logic [63:0] f_pc_o,
  output logic [63:0] f_predPC_o,
  output logic        redirect_o
);

  logic redirectJmp;
  logic redirectRet;
  logic predTaken;

`ifdef BTFNT_PRED_EN
  assign redirectJmp = (M_icode_i == I_JXX) && (M_Cnd_i != M_pred_taken_i);
`else
  assign redirectJmp = (M_icode_i == I_JXX) && !M_Cnd_i;
`endif
  assign redirectRet = (W_icode_i == I_RET);
  assign redirect_o  = redirectJmp || redirectRet;

  always_comb begin
    f_pc_o = predPc_i;
    if (redirectJmp)      f_pc_o = M_valA_i;
    else if (redirectRet) f_pc_o = W_valM_i;
  end

  // Unconditional jumps and backward branches are predicted taken; calls always go to valC.
`ifdef BTFNT_PRED_EN
  assign f_pred_taken_o = (f_icode_i == I_JXX) &&
                          ((f_ifun_i == 4'h0) || (f_valC_i <= f_pc_o));
  assign predTaken      = f_pred_taken_o || (f_icode_i == I_CALL);
`else
  assign predTaken      = (f_icode_i == I_JXX) || (f_icode_i == I_CALL);
`endif

  assign f_predPC_o = predTaken ? f_valC_i : f_valP_i;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Y86-64 fetch PC control: F register, run/drain/halt FSM and accepted-fetch counter.
// Optional BTFNT_PRED_EN selects BTFNT branch prediction inside pc_select.
module fetch_pc_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          COUNT_W  = 32
) (
  input logic           clk,
  input logic           rst_n,
  fetch_pc_ctrl_if.slave bus
);

  fetch_state_e       state_q, state_d;
  logic [63:0]        predPc_q, predPc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [63:0]        fPc, fPredPc;
  logic [2:0]         fStat;
  logic               redirect, accept;

  pc_select u_pc_select (
    .predPc_i       (predPc_q),
    .f_icode_i      (bus.f_icode),
`ifdef BTFNT_PRED_EN
    .f_ifun_i       (bus.f_ifun),
    .M_pred_taken_i (bus.M_pred_taken),
    .f_pred_taken_o (bus.f_pred_taken),
`endif
    .f_valC_i       (bus.f_valC),
    .f_valP_i       (bus.f_valP),
    .M_icode_i      (bus.M_icode),
    .M_Cnd_i        (bus.M_Cnd),
    .M_valA_i       (bus.M_valA),
    .W_icode_i      (bus.W_icode),
    .W_valM_i       (bus.W_valM),
    .f_pc_o         (fPc),
    .f_predPC_o     (fPredPc),
    .redirect_o     (redirect)
  );

  assign fStat  = fetch_status(bus.imem_error, bus.instr_valid, bus.f_icode);
  assign accept = (state_q == ST_RUN) && !bus.F_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      predPc_q <= RESET_PC;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      predPc_q <= predPc_d;
      count_q  <= count_d;
    end
  end

  // A pending writeback fault beats a same-cycle redirect out of DRAIN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (accept && (fStat != STAT_AOK)) state_d = ST_DRAIN;
      ST_DRAIN:  if (bus.W_stat != STAT_AOK)        state_d = ST_HALTED;
                 else if (redirect)                 state_d = ST_RUN;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    predPc_d = predPc_q;
    if (accept || (redirect && (state_q != ST_HALTED))) predPc_d = fPredPc;
    count_d = count_q;
    if (accept && (fStat == STAT_AOK) && !redirect) count_d = count_q + 1'b1;
  end

  always_comb begin
    bus.f_bubble = (state_q != ST_RUN);
    bus.halted   = (state_q == ST_HALTED);
  end

  assign bus.f_pc        = fPc;
  assign bus.f_predPC    = fPredPc;
  assign bus.f_stat      = fStat;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed self-checking bench for fetch_pc_ctrl with RESET_PC=0x40.
module tb_fetch_pc_ctrl;
  import y86_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fetch_pc_ctrl_if #(.COUNT_W(32)) bus ();

  fetch_pc_ctrl #(.RESET_PC(64'h40), .COUNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setDefaults();
    bus.F_stall     = 1'b0;
    bus.f_icode     = I_NOP;
    bus.f_ifun      = 4'h0;
    bus.f_valC      = 64'h0;
    bus.f_valP      = 64'h41;
    bus.imem_error  = 1'b0;
    bus.instr_valid = 1'b1;
    bus.M_icode     = I_NOP;
    bus.M_Cnd       = 1'b1;
    bus.M_valA      = 64'h0;
    bus.W_icode     = I_NOP;
    bus.W_valM      = 64'h0;
    bus.W_stat      = STAT_AOK;
`ifdef BTFNT_PRED_EN
    bus.M_pred_taken = 1'b1;
`endif
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    setDefaults();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Advance across one rising edge, landing 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    setDefaults();
    #1;
    checks++; if (bus.f_pc !== 64'h40) begin failures++; $display("[TB] FAIL reset_f_pc got=%h exp=%h", bus.f_pc, 64'h40); end
    checks++; if (bus.f_stat !== STAT_AOK) begin failures++; $display("[TB] FAIL reset_f_stat got=%0d exp=%0d", bus.f_stat, STAT_AOK); end
    checks++; if (bus.fetch_count !== 32'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", bus.fetch_count); end
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted got=%b exp=0", bus.halted); end
    checks++; if (bus.f_bubble !== 1'b0) begin failures++; $display("[TB] FAIL reset_bubble got=%b exp=0", bus.f_bubble); end
  endtask

  task automatic test_stat_priority();
    bus.imem_error = 1'b1; bus.instr_valid = 1'b0; bus.f_icode = I_HALT; #1;
    checks++; if (bus.f_stat !== STAT_ADR) begin failures++; $display("[TB] FAIL stat_adr got=%0d exp=%0d", bus.f_stat, STAT_ADR); end
    bus.imem_error = 1'b0; #1;
    checks++; if (bus.f_stat !== STAT_INS) begin failures++; $display("[TB] FAIL stat_ins got=%0d exp=%0d", bus.f_stat, STAT_INS); end
    bus.instr_valid = 1'b1; #1;
    checks++; if (bus.f_stat !== STAT_HLT) begin failures++; $display("[TB] FAIL stat_hlt got=%0d exp=%0d", bus.f_stat, STAT_HLT); end
    setDefaults();
  endtask

  task automatic test_nop_stream();
    logic [63:0] expPc;
    doReset();
    for (int i = 0; i < 3; i++) begin
      expPc = 64'h40 + 64'(i);
      bus.f_valP = expPc + 64'd1;
      #1;
      checks++; if (bus.f_pc !== expPc) begin failures++; $display("[TB] FAIL nop_f_pc[%0d] got=%h exp=%h", i, bus.f_pc, expPc); end
      step();
    end
    checks++; if (bus.fetch_count !== 32'd3) begin failures++; $display("[TB] FAIL nop_count got=%0d exp=3", bus.fetch_count); end
    checks++; if (bus.f_pc !== 64'h43) begin failures++; $display("[TB] FAIL nop_f_pc_end got=%h exp=43", bus.f_pc); end
  endtask

  task automatic test_jmp_mispredict();
    doReset();
    bus.f_icode = I_JXX; bus.f_ifun = 4'h1; bus.f_valC = 64'h100; bus.f_valP = 64'h49; #1;
    checks++; if (bus.f_predPC !== 64'h100) begin failures++; $display("[TB] FAIL jmp_pred got=%h exp=100", bus.f_predPC); end
    step();
    checks++; if (bus.f_pc !== 64'h100) begin failures++; $display("[TB] FAIL jmp_taken_pc got=%h exp=100", bus.f_pc); end
    bus.f_icode = I_NOP; bus.f_ifun = 4'h0; bus.f_valP = 64'h101;
    step();
    bus.M_icode = I_JXX; bus.M_Cnd = 1'b0; bus.M_valA = 64'h49; bus.f_valP = 64'h4A; #1;
    checks++; if (bus.f_pc !== 64'h49) begin failures++; $display("[TB] FAIL jmp_redirect_pc got=%h exp=49", bus.f_pc); end
    step();
    bus.M_icode = I_NOP; bus.M_Cnd = 1'b1; #1;
    checks++; if (bus.f_pc !== 64'h4A) begin failures++; $display("[TB] FAIL jmp_after_pc got=%h exp=4a", bus.f_pc); end
    checks++; if (bus.fetch_count !== 32'd2) begin failures++; $display("[TB] FAIL jmp_count got=%0d exp=2", bus.fetch_count); end
  endtask

  task automatic test_halt();
    doReset();
    bus.f_icode = I_HALT; bus.f_valP = 64'h41; #1;
    checks++; if (bus.f_stat !== STAT_HLT) begin failures++; $display("[TB] FAIL halt_stat got=%0d exp=%0d", bus.f_stat, STAT_HLT); end
    step();
    bus.f_icode = I_NOP; bus.f_valP = 64'h42; #1;
    checks++; if (bus.f_bubble !== 1'b1) begin failures++; $display("[TB] FAIL halt_bubble got=%b exp=1", bus.f_bubble); end
    step();
    step();
    bus.W_stat = STAT_HLT;
    checks++; if (bus.f_pc !== 64'h41) begin failures++; $display("[TB] FAIL drain_frozen got=%h exp=41", bus.f_pc); end
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("[TB] FAIL drain_not_halted got=%b exp=0", bus.halted); end
    step();
    checks++; if (bus.halted !== 1'b1) begin failures++; $display("[TB] FAIL halted_set got=%b exp=1", bus.halted); end
    bus.W_stat = STAT_AOK; bus.W_icode = I_RET; bus.W_valM = 64'h80;
    step();
    step();
    bus.W_icode = I_NOP; #1;
    checks++; if (bus.halted !== 1'b1) begin failures++; $display("[TB] FAIL halted_sticky got=%b exp=1", bus.halted); end
    checks++; if (bus.f_pc !== 64'h41) begin failures++; $display("[TB] FAIL halted_pc got=%h exp=41", bus.f_pc); end
    checks++; if (bus.fetch_count !== 32'd0) begin failures++; $display("[TB] FAIL halted_count got=%0d exp=0", bus.fetch_count); end
  endtask

  task automatic test_halt_wins();
    doReset();
    bus.f_icode = I_HALT;
    step();
    bus.f_icode = I_NOP;
    bus.W_stat = STAT_HLT; bus.M_icode = I_JXX; bus.M_Cnd = 1'b0; bus.M_valA = 64'h70;
    step();
    setDefaults(); #1;
    checks++; if (bus.halted !== 1'b1) begin failures++; $display("[TB] FAIL halt_wins got=%b exp=1", bus.halted); end
  endtask

  task automatic test_adr_recover();
    doReset();
    bus.imem_error = 1'b1; bus.f_valP = 64'h41; #1;
    checks++; if (bus.f_stat !== STAT_ADR) begin failures++; $display("[TB] FAIL adr_stat got=%0d exp=%0d", bus.f_stat, STAT_ADR); end
    step();
    bus.imem_error = 1'b0; #1;
    checks++; if (bus.f_bubble !== 1'b1) begin failures++; $display("[TB] FAIL adr_drain got=%b exp=1", bus.f_bubble); end
    bus.M_icode = I_JXX; bus.M_Cnd = 1'b0; bus.M_valA = 64'h60; bus.f_valP = 64'h61;
    step();
    bus.M_icode = I_NOP; bus.M_Cnd = 1'b1; bus.f_valP = 64'h62; #1;
    checks++; if (bus.f_bubble !== 1'b0) begin failures++; $display("[TB] FAIL adr_back_run got=%b exp=0", bus.f_bubble); end
    checks++; if (bus.f_pc !== 64'h61) begin failures++; $display("[TB] FAIL adr_pc got=%h exp=61", bus.f_pc); end
    step();
    checks++; if (bus.fetch_count !== 32'd1) begin failures++; $display("[TB] FAIL adr_count got=%0d exp=1", bus.fetch_count); end
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("[TB] FAIL adr_halted got=%b exp=0", bus.halted); end
  endtask

  task automatic test_stall_ret();
    doReset();
    bus.F_stall = 1'b1; bus.f_valP = 64'h41;
    step();
    checks++; if (bus.f_pc !== 64'h40) begin failures++; $display("[TB] FAIL stall_hold got=%h exp=40", bus.f_pc); end
    bus.W_icode = I_RET; bus.W_valM = 64'h80; bus.f_valP = 64'h81; #1;
    checks++; if (bus.f_pc !== 64'h80) begin failures++; $display("[TB] FAIL ret_select got=%h exp=80", bus.f_pc); end
    step();
    bus.W_icode = I_NOP; #1;
    checks++; if (bus.f_pc !== 64'h81) begin failures++; $display("[TB] FAIL ret_load got=%h exp=81", bus.f_pc); end
    checks++; if (bus.fetch_count !== 32'd0) begin failures++; $display("[TB] FAIL stall_count got=%0d exp=0", bus.fetch_count); end
    bus.F_stall = 1'b0; bus.f_icode = I_HALT; bus.f_valP = 64'h82;
    step();
    checks++; if (bus.f_bubble !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_drain got=%b exp=1", bus.f_bubble); end
    @(negedge clk);
    rst_n = 1'b0; setDefaults(); #1;
    checks++; if (bus.f_pc !== 64'h40) begin failures++; $display("[TB] FAIL midreset_pc got=%h exp=40", bus.f_pc); end
    checks++; if (bus.f_bubble !== 1'b0) begin failures++; $display("[TB] FAIL midreset_run got=%b exp=0", bus.f_bubble); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    setDefaults();
    test_reset();
    test_stat_priority();
    test_nop_stream();
    test_jmp_mispredict();
    test_halt();
    test_halt_wins();
    test_adr_recover();
    test_stall_ret();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
